decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 24 ++
 rtl/decode_stage_reg_file.sv | 39 +++
 rtl/decode_stage.sv | 75 +++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: op encodings, bubble word, immediate helpers.
package decode_stage_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
   localparam logic [3:0]  PC_REG      = 4'd15;

   // Rotate-right of a zero-extended imm8 by twice the rot field
   function automatic logic [31:0] rot_imm(
      input logic [7:0] imm8,
      input logic [3:0] rot
   );
      logic [63:0] dbl;
      dbl = {24'b0, imm8, 24'b0, imm8} >> {rot, 1'b0};
      return dbl[31:0];
   endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// R0-R14 register file; R15 reads as PC+8, same-cycle writeback bypass.
module decode_stage_reg_file
   import decode_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [3:0]  wa,
   input  logic [31:0] wd,
   input  logic [3:0]  ra1,
   input  logic [3:0]  ra2,
   input  logic [31:0] r15,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [0:14];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
      end else if (we && wa != PC_REG) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      if (ra1 == PC_REG)   rd1 = r15;
      else if (we && wa == ra1) rd1 = wd;
      else                 rd1 = regs[ra1];
   end

   always_comb begin
      if (ra2 == PC_REG)   rd2 = r15;
      else if (we && wa == ra2) rd2 = wd;
      else                 rd2 = regs[ra2];
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: pipeline register, source select, immediate extend,
// and register file read.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_D,
   input  logic        flush_D,
   input  logic [31:0] Instr_F,
   input  logic [31:0] PCPlus4_F,
   input  logic        RegWrite_W,
   input  logic [3:0]  WA3_W,
   input  logic [31:0] Result_W,
   output logic [31:0] Instr_D,
   output logic        valid_D,
   output logic [3:0]  RA1_D,
   output logic [3:0]  RA2_D,
   output logic [31:0] RD1_D,
   output logic [31:0] RD2_D,
   output logic [31:0] ExtImm_D,
   output logic [31:0] PCPlus8_D
);

   logic [31:0] PCPlus4_D;
   op_e         op;

   // Flush takes priority over stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Instr_D   <= NOP_INSTR;
         PCPlus4_D <= '0;
         valid_D   <= 1'b0;
      end else if (flush_D) begin
         Instr_D   <= NOP_INSTR;
         PCPlus4_D <= '0;
         valid_D   <= 1'b0;
      end else if (!stall_D) begin
         Instr_D   <= Instr_F;
         PCPlus4_D <= PCPlus4_F;
         valid_D   <= 1'b1;
      end
   end

   assign op        = op_e'(Instr_D[27:26]);
   assign PCPlus8_D = PCPlus4_D + 32'd4;
   assign RA1_D     = (op == OP_BR)  ? PC_REG : Instr_D[19:16];
   assign RA2_D     = (op == OP_MEM) ? Instr_D[15:12] : Instr_D[3:0];

   always_comb begin
      ExtImm_D = '0;
      unique case (op)
         OP_DP:  ExtImm_D = rot_imm(Instr_D[7:0], Instr_D[11:8]);
         OP_MEM: ExtImm_D = {20'b0, Instr_D[11:0]};
         OP_BR:  ExtImm_D = {{6{Instr_D[23]}}, Instr_D[23:0], 2'b00};
         OP_RSV: ExtImm_D = '0;
      endcase
   end

   decode_stage_reg_file reg_file (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (RegWrite_W),
      .wa    (WA3_W),
      .wd    (Result_W),
      .ra1   (RA1_D),
      .ra2   (RA2_D),
      .r15   (PCPlus8_D),
      .rd1   (RD1_D),
      .rd2   (RD2_D)
   );

endmodule
